lcb_frame_packer: RTL and testbench

- Transmit-side counterpart of the LCB frame unpacker.
- On a request, reads 12 ten-bit measures from the sample memory and packs them into a 15-byte LCB frame: three groups of 5 bytes.
- Each group is one MSB byte followed by four LSB bytes.
- Bytes are handed one at a time to the UART transmitter over a level handshake.

---
 rtl/lcb_frame_packer.sv | 172 +++++++++++++++++
 tb/tb_lcb_frame_packer.sv | 535 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcb_frame_packer.sv
// LCB frame packer: fetches 12 ten-bit measures from sample memory and
// streams them to the UART as a 15-byte frame (3 x {MSB byte, 4 LSB bytes}).
module lcb_frame_packer #(
    parameter int RD_LAT     = 2,
    parameter int NUM_FRAMES = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rqValid,
    input  logic [4:0] rqNumber,
    output logic [8:0] smpAddr,
    output logic       smpRdEn,
    input  logic [9:0] smpData,
    output logic [7:0] txData,
    output logic       txStart,
    input  logic       txBusy,
    output logic       busy,
    output logic       frameDone,
    output logic       rqError,
    output logic       test
);
    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_IDLE, START, WAIT_DONE
    } state_t;

    localparam logic [2:0] LAT        = 3'(RD_LAT);
    localparam logic [1:0] LAT2       = 2'(RD_LAT);
    localparam logic [2:0] FETCH_LAST = 3'(RD_LAT + 3);
    localparam logic [5:0] NF         = 6'(NUM_FRAMES);

    state_t          state_q, state_d;
    logic [8:0]      base_q, base_d;
    logic [1:0]      grp_q, grp_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [2:0]      fcnt_q, fcnt_d;
    logic [3:0][9:0] m_q, m_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [3:0] pos;
    logic [1:0] cap;
    logic [7:0] byte_val;

    // position within the current group and the read slot landing this cycle
    assign pos = bcnt_q - ({grp_q, 2'b00} + {2'b00, grp_q});
    assign cap = fcnt_q[1:0] - LAT2;

    always_comb begin
        byte_val = 8'h00;
        case (pos)
            4'd0: byte_val = {m_q[0][9:8], m_q[1][9:8],
                              m_q[2][9:8], m_q[3][9:8]};
            4'd1: byte_val = m_q[0][7:0];
            4'd2: byte_val = m_q[1][7:0];
            4'd3: byte_val = m_q[2][7:0];
            4'd4: byte_val = m_q[3][7:0];
            default: byte_val = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        grp_d   = grp_q;
        bcnt_d  = bcnt_q;
        fcnt_d  = fcnt_q;
        m_d     = m_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        smpRdEn = 1'b0;
        smpAddr = 9'd0;
        txStart = 1'b0;
        txData  = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (rqValid) begin
                    if ({1'b0, rqNumber} < NF) begin
                        base_d  = 9'({rqNumber, 3'b000})
                                + 9'({rqNumber, 2'b00});
                        busy_d  = 1'b1;
                        grp_d   = 2'd0;
                        bcnt_d  = 4'd0;
                        fcnt_d  = 3'd0;
                        state_d = FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                fcnt_d = fcnt_q + 3'd1;
                if (fcnt_q < 3'd4) begin
                    smpRdEn = 1'b1;
                    smpAddr = base_q + {5'd0, grp_q, 2'b00}
                            + {7'd0, fcnt_q[1:0]};
                end
                if (fcnt_q >= LAT) begin
                    m_d[cap] = smpData;
                end
                if (fcnt_q == FETCH_LAST) begin
                    fcnt_d  = 3'd0;
                    state_d = txBusy ? WAIT_IDLE : START;
                end
            end
            WAIT_IDLE: begin
                txData = byte_val;
                if (!txBusy) begin
                    state_d = START;
                end
            end
            START: begin
                txData  = byte_val;
                txStart = 1'b1;
                if (txBusy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                txData = byte_val;
                if (!txBusy) begin
                    if (pos != 4'd4) begin
                        bcnt_d  = bcnt_q + 4'd1;
                        state_d = START;
                    end else if (grp_q != 2'd2) begin
                        bcnt_d  = bcnt_q + 4'd1;
                        grp_d   = grp_q + 2'd1;
                        state_d = FETCH;
                    end else begin
                        bcnt_d  = 4'd0;
                        grp_d   = 2'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= 9'd0;
            grp_q   <= 2'd0;
            bcnt_q  <= 4'd0;
            fcnt_q  <= 3'd0;
            m_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            grp_q   <= grp_d;
            bcnt_q  <= bcnt_d;
            fcnt_q  <= fcnt_d;
            m_q     <= m_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = busy_q;
    assign frameDone = done_q;
    assign rqError   = err_q;
    assign test      = bcnt_q[3];

endmodule

// File: tb/tb_lcb_frame_packer.sv
// Bench for lcb_frame_packer: sample-memory and UART models, expected
// bytes queued at request time and matched against bytes the UART takes.
module tb_lcb_frame_packer;
    localparam int RD_LAT     = 2;
    localparam int NUM_FRAMES = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rqValid = 1'b0;
    logic [4:0] rqNumber = 5'd0;
    logic [8:0] smpAddr;
    logic       smpRdEn;
    logic [9:0] smpData;
    logic [7:0] txData;
    logic       txStart;
    logic       txBusy;
    logic       busy;
    logic       frameDone;
    logic       rqError;
    logic       test;

    lcb_frame_packer #(
        .RD_LAT    (RD_LAT),
        .NUM_FRAMES(NUM_FRAMES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rqValid  (rqValid),
        .rqNumber (rqNumber),
        .smpAddr  (smpAddr),
        .smpRdEn  (smpRdEn),
        .smpData  (smpData),
        .txData   (txData),
        .txStart  (txStart),
        .txBusy   (txBusy),
        .busy     (busy),
        .frameDone(frameDone),
        .rqError  (rqError),
        .test     (test)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // sample memory with RD_LAT-deep read pipeline
    logic [9:0] mem [0:511];
    logic [9:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= smpRdEn ? mem[smpAddr] : 10'h3A5;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign smpData = rd_pipe[RD_LAT-1];

    // UART: busy one cycle after txStart, for 10 cycles
    logic       uart_busy = 1'b0;
    logic       hold_busy = 1'b0;
    int         ucnt = 0;
    int         got_n = 0;
    logic [7:0] got_mem [0:511];
    assign txBusy = uart_busy | hold_busy;
    always @(posedge clk) begin
        if (ucnt != 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) uart_busy <= 1'b0;
        end else if (txStart && !txBusy) begin
            uart_busy       <= 1'b1;
            ucnt            <= 10;
            got_mem[got_n]  <= txData;
            got_n           <= got_n + 1;
        end
    end

    // protocol monitor
    int         cyc = 0;
    int         addr_n = 0;
    logic [8:0] addr_log [0:1023];
    int         done_n = 0;
    int         err_n = 0;
    int         start_n = 0;
    int         start_cyc = 0;
    int         req_cyc = 0;
    int         bad_n = 0;
    logic       prev_start = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_start <= txStart;
        prev_busy  <= txBusy;
        prev_data  <= txData;
        if (smpRdEn) begin
            addr_log[addr_n] <= smpAddr;
            addr_n           <= addr_n + 1;
        end
        if (frameDone) done_n <= done_n + 1;
        if (rqError) err_n <= err_n + 1;
        if (rqValid) req_cyc <= cyc;
        if (txStart && !prev_start) begin
            start_n   <= start_n + 1;
            start_cyc <= cyc;
        end
        if ((frameDone && busy)
            || (txStart && !prev_start && txBusy)
            || (txStart && prev_start && txData !== prev_data)
            || (!txStart && prev_start && !prev_busy))
            bad_n <= bad_n + 1;
    end

    logic [7:0] exp_q [$];
    int         rd_idx = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [4:0] n);
        @(posedge clk);
        #1;
        rqValid  = 1'b1;
        rqNumber = n;
        tick(1);
        rqValid = 1'b0;
    endtask

    task automatic push_frame(input int n);
        logic [9:0] w [4];
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 4; k++) w[k] = mem[n*12 + g*4 + k];
            exp_q.push_back({w[0][9:8], w[1][9:8], w[2][9:8], w[3][9:8]});
            for (int k = 0; k < 4; k++) exp_q.push_back(w[k][7:0]);
        end
    endtask

    task automatic wait_done(input int d0, output bit to);
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done_n > d0) begin
                to = 1'b0;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_bytes(input int target, output bit to);
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (got_n >= target) begin
                to = 1'b0;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        checks++;
        if ({busy, txStart, smpRdEn, frameDone, rqError, test} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000",
                     {busy, txStart, smpRdEn, frameDone, rqError, test});
        end
        checks++;
        if (smpAddr !== 9'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d exp 0", smpAddr);
        end
        checks++;
        if (txData !== 8'd0) begin
            errors++;
            $display("FAIL reset_txdata got %h exp 00", txData);
        end
    endtask

    task automatic test_frame();
        int g0 = got_n;
        int a0 = addr_n;
        int d0 = done_n;
        int b0 = bad_n;
        bit to;
        logic [7:0] k5 [5] = '{8'hC9, 8'hFF, 8'h00, 8'hAA, 8'h55};
        logic [7:0] eb;
        push_frame(2);
        send_req(5'd2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_busy got %b exp 1", busy);
        end
        wait_done(d0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL frame_done timeout got none exp pulse");
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_busy_end got %b exp 0", busy);
        end
        tick(5);
        checks++;
        if (done_n - d0 != 1) begin
            errors++;
            $display("FAIL frame_donecnt got %0d exp 1", done_n - d0);
        end
        checks++;
        if (got_n - g0 != 15) begin
            errors++;
            $display("FAIL frame_bytes got %0d exp 15", got_n - g0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_mem[g0+i] !== k5[i]) begin
                errors++;
                $display("FAIL frame_const b%0d got %h exp %h",
                         i, got_mem[g0+i], k5[i]);
            end
        end
        checks++;
        if (addr_n - a0 != 12) begin
            errors++;
            $display("FAIL frame_reads got %0d exp 12", addr_n - a0);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (addr_log[a0+i] !== 9'(24 + i)) begin
                errors++;
                $display("FAIL frame_addr%0d got %0d exp %0d",
                         i, addr_log[a0+i], 24 + i);
            end
        end
        while (rd_idx < got_n) begin
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_mem[rd_idx] !== eb) begin
                errors++;
                $display("FAIL frame_sb byte%0d got %h exp %h",
                         rd_idx, got_mem[rd_idx], eb);
            end
            rd_idx++;
        end
        checks++;
        if (bad_n != b0) begin
            errors++;
            $display("FAIL frame_proto got %0d exp 0", bad_n - b0);
        end
    endtask

    task automatic test_latency();
        int s0 = start_n;
        int d0 = done_n;
        bit to;
        logic [7:0] eb;
        push_frame(0);
        send_req(5'd0);
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (start_n > s0) begin
                to = 1'b0;
                break;
            end
            tick(1);
        end
        checks++;
        if (to || start_cyc - req_cyc != 5 + RD_LAT) begin
            errors++;
            $display("FAIL latency got %0d exp %0d (timeout=%0d)",
                     start_cyc - req_cyc, 5 + RD_LAT, to);
        end
        wait_done(d0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL latency_done timeout got none exp pulse");
        end
        while (rd_idx < got_n) begin
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_mem[rd_idx] !== eb) begin
                errors++;
                $display("FAIL latency_sb byte%0d got %h exp %h",
                         rd_idx, got_mem[rd_idx], eb);
            end
            rd_idx++;
        end
    endtask

    task automatic test_bad_request();
        int e0 = err_n;
        int a0 = addr_n;
        int s0 = start_n;
        send_req(5'(NUM_FRAMES));
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL badreq_busy got %b exp 0", busy);
        end
        tick(10);
        checks++;
        if (err_n - e0 != 1) begin
            errors++;
            $display("FAIL badreq_err got %0d exp 1", err_n - e0);
        end
        checks++;
        if (addr_n != a0 || start_n != s0) begin
            errors++;
            $display("FAIL badreq_activity got reads=%0d starts=%0d exp 0 0",
                     addr_n - a0, start_n - s0);
        end
    endtask

    task automatic test_back_to_back();
        int g0 = got_n;
        int d0 = done_n;
        int e0 = err_n;
        int a1;
        bit to;
        logic [7:0] eb;
        push_frame(3);
        send_req(5'd3);
        wait_bytes(g0 + 8, to);
        send_req(5'd7);
        wait_done(d0, to);
        tick(5);
        checks++;
        if (to || done_n - d0 != 1 || got_n - g0 != 15) begin
            errors++;
            $display("FAIL ignore_req got done=%0d bytes=%0d exp 1 15",
                     done_n - d0, got_n - g0);
        end
        checks++;
        if (err_n != e0) begin
            errors++;
            $display("FAIL ignore_err got %0d exp 0", err_n - e0);
        end
        g0 = got_n;
        d0 = done_n;
        a1 = addr_n;
        push_frame(4);
        send_req(5'd4);
        wait_done(d0, to);
        tick(2);
        checks++;
        if (to || got_n - g0 != 15 || addr_log[a1] !== 9'd48) begin
            errors++;
            $display("FAIL next_req got bytes=%0d addr=%0d exp 15 48",
                     got_n - g0, addr_log[a1]);
        end
        while (rd_idx < got_n) begin
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_mem[rd_idx] !== eb) begin
                errors++;
                $display("FAIL b2b_sb byte%0d got %h exp %h",
                         rd_idx, got_mem[rd_idx], eb);
            end
            rd_idx++;
        end
    endtask

    task automatic test_stuck_busy();
        int s0;
        int d0 = done_n;
        int b0 = bad_n;
        bit to;
        logic [7:0] eb;
        reset = 1'b1;
        hold_busy = 1'b1;
        tick(1);
        reset = 1'b0;
        s0 = start_n;
        push_frame(5);
        send_req(5'd5);
        tick(19);
        checks++;
        if (start_n != s0 || txStart !== 1'b0) begin
            errors++;
            $display("FAIL stuck_start got %0d exp 0", start_n - s0);
        end
        hold_busy = 1'b0;
        wait_done(d0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL stuck_done timeout got none exp pulse");
        end
        checks++;
        if (bad_n != b0) begin
            errors++;
            $display("FAIL stuck_proto got %0d exp 0", bad_n - b0);
        end
        while (rd_idx < got_n) begin
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_mem[rd_idx] !== eb) begin
                errors++;
                $display("FAIL stuck_sb byte%0d got %h exp %h",
                         rd_idx, got_mem[rd_idx], eb);
            end
            rd_idx++;
        end
    endtask

    task automatic test_reset_midframe();
        int g0 = got_n;
        int d0;
        int a1;
        bit to;
        logic [7:0] eb;
        push_frame(6);
        send_req(5'd6);
        wait_bytes(g0 + 10, to);
        tick(3);
        checks++;
        if (test !== 1'b1) begin
            errors++;
            $display("FAIL midreset_test_pre got %b exp 1", test);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if ({txStart, busy, smpRdEn, test} !== 4'b0
            || smpAddr !== 9'd0 || txData !== 8'd0) begin
            errors++;
            $display("FAIL midreset_out got %b/%0d/%h exp 0000/0/00",
                     {txStart, busy, smpRdEn, test}, smpAddr, txData);
        end
        tick(20);
        checks++;
        if (got_n - g0 != 10) begin
            errors++;
            $display("FAIL midreset_bytes got %0d exp 10", got_n - g0);
        end
        while (rd_idx < got_n) begin
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_mem[rd_idx] !== eb) begin
                errors++;
                $display("FAIL midreset_sb byte%0d got %h exp %h",
                         rd_idx, got_mem[rd_idx], eb);
            end
            rd_idx++;
        end
        exp_q.delete();
        g0 = got_n;
        d0 = done_n;
        a1 = addr_n;
        push_frame(1);
        send_req(5'd1);
        wait_done(d0, to);
        tick(2);
        checks++;
        if (to || got_n - g0 != 15 || addr_log[a1] !== 9'd12) begin
            errors++;
            $display("FAIL midreset_next got bytes=%0d addr=%0d exp 15 12",
                     got_n - g0, addr_log[a1]);
        end
        while (rd_idx < got_n) begin
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_mem[rd_idx] !== eb) begin
                errors++;
                $display("FAIL midreset2_sb byte%0d got %h exp %h",
                         rd_idx, got_mem[rd_idx], eb);
            end
            rd_idx++;
        end
    endtask

    task automatic test_last_frame();
        int a0 = addr_n;
        int d0 = done_n;
        bit to;
        logic [7:0] eb;
        push_frame(NUM_FRAMES - 1);
        send_req(5'(NUM_FRAMES - 1));
        wait_done(d0, to);
        tick(2);
        checks++;
        if (to || addr_n - a0 != 12) begin
            errors++;
            $display("FAIL last_reads got %0d exp 12", addr_n - a0);
        end
        checks++;
        if (addr_log[a0+11] !== 9'(12*NUM_FRAMES - 1)) begin
            errors++;
            $display("FAIL last_addr got %0d exp %0d",
                     addr_log[a0+11], 12*NUM_FRAMES - 1);
        end
        while (rd_idx < got_n) begin
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got_mem[rd_idx] !== eb) begin
                errors++;
                $display("FAIL last_sb byte%0d got %h exp %h",
                         rd_idx, got_mem[rd_idx], eb);
            end
            rd_idx++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 10'((i * 167 + 89) % 1024);
        mem[24] = 10'h3FF;
        mem[25] = 10'h000;
        mem[26] = 10'h2AA;
        mem[27] = 10'h155;
        test_reset();
        test_frame();
        test_latency();
        test_bad_request();
        test_back_to_back();
        test_stuck_busy();
        test_reset_midframe();
        test_last_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
